gemm_requant_pack: RTL and testbench
====================================

// Module: gemm_requant_pack
// PURPOSE
// - Downstream of the GEMM core. Consumes the signed ACC_WIDTH accumulator stream (valid/ready).
// - Per element: adds a bias, multiplies by a fixed-point scale, then does a rounding arithmetic right shift.
// - Saturates each result to signed OUT_WIDTH and packs PACK lanes into one output word for the writeback/DMA stage.
// - in_last flushes a partial word at the end of a tile.
// PARAMETERS
// - ACC_WIDTH  32  width of the signed input accumulator
// - OUT_WIDTH  8   width of each signed saturated output lane
// - PACK       4   lanes per output word (>=1); lane 0 sits in the LSBs
// - MULT_WIDTH 16  width of the signed scale multiplier
// PORTS
// - clk             in   1                  clock
// - rst_n           in   1                  async active-low reset
// - cfg_bias        in   ACC_WIDTH          signed bias added to each accumulator
// - cfg_mult        in   MULT_WIDTH         signed scale
// - cfg_shift       in   5                  right-shift amount, 0..31
// - cfg_clear_perf  in   1                  synchronous clear of perf_sat_count
// - in_valid        in   1                  accumulator valid
// - in_ready        out  1                  block can accept
// - in_data         in   ACC_WIDTH          signed accumulator
// - in_last         in   1                  last element of tile
// - out_valid       out  1                  packed word valid
// - out_ready       in   1                  downstream accepts
// - out_data        out  PACK*OUT_WIDTH     packed lanes
// - out_last        out  1                  word contains the tile's last lane
// - out_lane_mask   out  PACK               1 per populated lane
// - busy            out  1                  any stage or pack register occupied
// - perf_sat_count  out  32                 count of clipped lanes
// BEHAVIOUR
// - Reset: all outputs 0, except in_ready, which is 1 (adv=1 with out_valid=0); pipeline valids 0, lane count 0.
//   Reset mid-operation discards all in-flight data.
// - Advance: adv = !out_valid || out_ready; in_ready = adv. All stages hold when adv=0; there is no bubble squashing.
// - S1 (on a fire): p = (in_data + cfg_bias) * cfg_mult.
//   - Sum is computed at ACC_WIDTH+1 bits; product at ACC_WIDTH+1+MULT_WIDTH bits, full precision, no overflow.
//   - in_last is carried alongside p.
// - S2 (when S1 valid and adv): r = (p + (shift>0 ? 2^(shift-1) : 0)) >>> shift, i.e. round half toward +inf.
//   - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//   - A clip increments perf_sat_count, which wraps at 2^32.
//   - The lane is written to lane index cnt; out_lane_mask[cnt] is set and cnt increments.
// - Word completes when cnt reaches PACK or when the lane carries last.
//   - Next edge: out_valid=1, out_last=last, and cnt resets to 0.
//   - Unpopulated lanes read 0.
// - Latency: the PACK-th input accepted at edge t gives out_valid high after edge t+2.
// - Full with out_ready=1 and S1 valid in the same cycle: the word is handed off, the new lane lands in lane 0 of a
//   cleared word, and the mask becomes 1 in that same edge.
// - out_valid=1 and out_ready=0: out_data, out_last and out_lane_mask are held stable; in_ready=0.
// - cfg_clear_perf and a clip in the same cycle: the clear wins and the count becomes 0.
// - busy = S1 valid || cnt!=0 || out_valid.
// - cfg_bias, cfg_mult and cfg_shift are sampled live; they may change only while busy=0 && in_valid=0.
// CONFIGURATION
// - GEMM_REQUANT_RELU_EN defined:
//   - After saturation, negative lanes are forced to 0.
//   - The saturation count still counts clips of the pre-ReLU value.
// - Undefined: signed saturated values pass through unchanged.
// TESTING
// - T1 pass-through (bias=0, mult=1, shift=0, PACK=4): inputs 1, -2, 3, -4, out_ready=1
//   -> out_data=0xFC03FE01, mask=0xF, out_last=0, sat=0.
// - T2 rounding (mult=1, shift=2): inputs 5, 6, -6, -5 -> lanes 1, 2, -1, -1.
// - T3 saturation (mult=1000, shift=0): inputs 1, -1, 0, 0
//   -> lanes 127, -128, 0, 0; sat=2 (with RELU_EN: lanes 127, 0, 0, 0).
// - T4 partial flush: 2 inputs 7, 8 with in_last on the 2nd -> out_data=0x00000807, mask=0x3, out_last=1.
// - T5 backpressure: hold out_ready=0 for 10 cycles after a word completes
//   -> in_ready=0 and out_data stable; on release 8 back-to-back inputs produce 2 words with no loss.
// - T6 reset mid-stream: assert rst_n=0 after 2 lanes
//   -> out_valid=0, busy=0, sat=0; the next 4 inputs form a clean word with mask=0xF.

Source files
------------

// File: rtl/gemm_requant_pack.sv
// gemm_requant_pack
//   Requantises the signed accumulator stream from the GEMM core and packs
//   PACK saturated lanes into one output word for the writeback/DMA stage.
//   Per element: p = (acc + bias) * mult, then r = round_half_up(p >> shift),
//   saturated to signed OUT_WIDTH. in_last flushes a partial word.
//
//   Optional build macro: GEMM_REQUANT_RELU_EN
//     defined   -> negative saturated lanes are forced to 0 (clips are still
//                  counted on the pre-ReLU value)
//     undefined -> saturated lanes pass through unchanged
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_bias/mult/shift live requant configuration (change only when idle)
//   cfg_clear_perf      synchronous clear of perf_sat_count (wins over a clip)
//   in_valid/ready/data/last   accumulator stream
//   out_valid/ready/data/last  packed word stream, lane 0 in the LSBs
//   out_lane_mask       one bit per populated lane
//   busy                any pipeline stage or pack register occupied
//   perf_sat_count      wrapping count of clipped lanes
module gemm_requant_pack #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int PACK       = 4,
  parameter int MULT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ACC_WIDTH-1:0]      cfg_bias,
  input  logic [MULT_WIDTH-1:0]     cfg_mult,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_clear_perf,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_WIDTH-1:0]      in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PACK*OUT_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic [PACK-1:0]           out_lane_mask,
  output logic                      busy,
  output logic [31:0]               perf_sat_count
);

  localparam int SW = ACC_WIDTH + 1;               // bias sum width
  localparam int PW = ACC_WIDTH + 1 + MULT_WIDTH;  // full-precision product
  localparam int RW = PW + 1;                      // headroom for rounding add
  localparam int CW = $clog2(PACK + 1);            // lane count 0..PACK

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Whole pipeline moves together; a stalled output word freezes every stage.
  logic adv;

  // Stage 1 registers
  logic                 s1_valid_reg;
  logic                 s1_last_reg;
  logic signed [PW-1:0] p_reg;
  logic signed [SW-1:0] sum_next;
  logic signed [PW-1:0] p_next;

  // Stage 2 / pack state
  logic [CW-1:0]        cnt_reg;
  logic [CW-1:0]        base_cnt;
  logic                 done_reg;      // pack word complete, hand off next edge
  logic                 pack_last_reg;
  logic                 word_end;
  logic [PACK*OUT_WIDTH-1:0] pack_data;
  logic [PACK-1:0]           pack_mask;

  // Output registers
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic [PACK*OUT_WIDTH-1:0] out_data_reg;
  logic [PACK-1:0]           out_mask_reg;
  logic [31:0]               perf_reg;

  // Requant datapath
  logic signed [RW-1:0]  p_ext;
  logic        [RW-1:0]  half_u;
  logic signed [RW-1:0]  r_val;
  logic                  clip_hi;
  logic                  clip_lo;
  logic [OUT_WIDTH-1:0]  lane_sat;
  logic [OUT_WIDTH-1:0]  lane_val;

  assign adv      = !out_valid_reg || out_ready;
  assign in_ready = adv;

  always_comb begin
    sum_next = SW'($signed(in_data)) + SW'($signed(cfg_bias));
    p_next   = PW'(sum_next) * PW'($signed(cfg_mult));
  end

  always_comb begin
    p_ext  = RW'(p_reg);
    // 2^(shift-1) for shift>0, 0 for shift==0
    half_u = (RW'(1) << cfg_shift) >> 1;
    r_val  = (p_ext + $signed(half_u)) >>> cfg_shift;
    clip_hi = r_val > SAT_MAX;
    clip_lo = r_val < SAT_MIN;
    if (clip_hi)      lane_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (clip_lo) lane_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else              lane_sat = r_val[OUT_WIDTH-1:0];
`ifdef GEMM_REQUANT_RELU_EN
    lane_val = lane_sat[OUT_WIDTH-1] ? '0 : lane_sat;
`else
    lane_val = lane_sat;
`endif
  end

  // A completed word is handed off on the same edge a new lane may land,
  // so the new lane always starts from index 0 of a cleared word.
  assign base_cnt = done_reg ? '0 : cnt_reg;
  assign word_end = (base_cnt == CW'(PACK - 1)) || s1_last_reg;

  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      logic [OUT_WIDTH-1:0] lane_reg;
      logic                 lane_vld_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg     <= '0;
          lane_vld_reg <= 1'b0;
        end else if (adv) begin
          if (s1_valid_reg && (base_cnt == CW'(gi))) begin
            lane_reg     <= lane_val;
            lane_vld_reg <= 1'b1;
          end else if (done_reg) begin
            lane_reg     <= '0;
            lane_vld_reg <= 1'b0;
          end
        end
      end

      assign pack_data[gi*OUT_WIDTH +: OUT_WIDTH] = lane_reg;
      assign pack_mask[gi]                        = lane_vld_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      p_reg         <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      pack_last_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_mask_reg  <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        p_reg       <= p_next;
        s1_last_reg <= in_last;
      end
      if (s1_valid_reg) begin
        cnt_reg  <= base_cnt + CW'(1);
        done_reg <= word_end;
      end else begin
        cnt_reg  <= base_cnt;
        done_reg <= 1'b0;
      end
      // Only a word's final lane can carry last, so tracking the newest lane suffices.
      pack_last_reg <= s1_valid_reg && s1_last_reg;
      if (done_reg) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= pack_data;
        out_mask_reg  <= pack_mask;
        out_last_reg  <= pack_last_reg;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= '0;
    end else if (cfg_clear_perf) begin
      perf_reg <= '0;
    end else if (adv && s1_valid_reg && (clip_hi || clip_lo)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_data       = out_data_reg;
  assign out_last       = out_last_reg;
  assign out_lane_mask  = out_mask_reg;
  assign perf_sat_count = perf_reg;
  assign busy           = s1_valid_reg || (cnt_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_gemm_requant_pack.sv
`timescale 1ns/1ps
module tb_gemm_requant_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] cfg_bias;
  logic [15:0] cfg_mult;
  logic [4:0]  cfg_shift;
  logic        cfg_clear_perf;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  out_lane_mask;
  logic        busy;
  logic [31:0] perf_sat_count;

  gemm_requant_pack #(
    .ACC_WIDTH(32), .OUT_WIDTH(8), .PACK(4), .MULT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_clear_perf(cfg_clear_perf),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_lane_mask(out_lane_mask),
    .busy(busy), .perf_sat_count(perf_sat_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } word_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  word_t       exp_q[$];
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  int          m_cnt;
  int unsigned m_sat;
  int          cyc = 0;
  int          last_fire_cyc = 0;
  int          last_out_cyc = 0;
  int          n_words = 0;
  logic [31:0] got_data;
  logic [3:0]  got_mask;
  logic        got_last;
  logic        clr_drv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_data = '0;
    m_mask = '0;
    m_cnt  = 0;
    m_sat  = 0;
  endtask

  // Reference: exact integer arithmetic, floor division for the rounded shift.
  task automatic ref_lane(input logic [31:0] d, output logic [7:0] lane, output bit clip);
    longint p, q, r, dv, half;
    p    = (longint'($signed(d)) + longint'($signed(cfg_bias))) * longint'($signed(cfg_mult));
    dv   = longint'(1) << cfg_shift;
    half = (cfg_shift == 0) ? 0 : dv / 2;
    q    = p + half;
    r    = q / dv;
    if ((q % dv) != 0 && q < 0) r = r - 1;
    clip = (r > 127) || (r < -128);
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
`ifdef GEMM_REQUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    lane = r[7:0];
  endtask

  task automatic model_accept(input logic [31:0] d, input bit l);
    logic [7:0] lane;
    bit clip;
    word_t w;
    ref_lane(d, lane, clip);
    if (clip) m_sat++;
    m_data[m_cnt*8 +: 8] = lane;
    m_mask[m_cnt] = 1'b1;
    m_cnt++;
    if (m_cnt == 4 || l) begin
      w.data = m_data; w.mask = m_mask; w.last = l;
      exp_q.push_back(w);
      m_data = '0; m_mask = '0; m_cnt = 0;
    end
  endtask

  task automatic take_word();
    word_t w;
    n_words++;
    got_data = out_data; got_mask = out_lane_mask; got_last = out_last;
    last_out_cyc = cyc;
    $display("word %0d @cyc %0d: data=0x%08h mask=0x%0h last=%0b", n_words, cyc, out_data, out_lane_mask, out_last);
    check("word_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      check("word_data", out_data, w.data);
      check("word_mask", out_lane_mask, w.mask);
      check("word_last", out_last, w.last);
    end
  endtask

  // One clock: drive just after a falling edge, observe handshakes before the rising edge.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit ordy, output bit fired);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy; cfg_clear_perf = clr_drv;
    #1;
    fired = v && in_ready;
    if (fired) begin
      model_accept(d, l);
      last_fire_cyc = cyc;
    end
    if (out_valid && out_ready) take_word();
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [31:0] d, input bit l, input int rdy_pct);
    bit f;
    int tries;
    f = 0; tries = 0;
    while (!f && tries < 50) begin
      step(1'b1, d, l, $urandom_range(99) < rdy_pct, f);
      tries++;
    end
    check("send_accepted", f, 1);
  endtask

  task automatic drain();
    bit f;
    for (int i = 0; i < 40 && busy; i++) step(1'b0, '0, 1'b0, 1'b1, f);
    check("drain_idle", busy, 0);
    check("queue_empty", exp_q.size(), 0);
    check("sat_count", perf_sat_count, m_sat);
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [15:0] m, input logic [4:0] s);
    cfg_bias = b; cfg_mult = m; cfg_shift = s;
  endtask

  task automatic clear_perf();
    bit f;
    clr_drv = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1, f);
    clr_drv = 1'b0;
    m_sat = 0;
  endtask

  initial begin
    bit f;
    logic [31:0] snap, exp_w;
    int words0, cyc0, len, mode, pct;

    rst_n = 1'b0; clr_drv = 1'b0; cfg_clear_perf = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    set_cfg(32'd0, 16'd1, 5'd0);
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_perf", perf_sat_count, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mask", out_lane_mask, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // T1 pass-through and latency
    set_cfg(32'd0, 16'd1, 5'd0);
    send(1, 0, 100); send(-2, 0, 100); send(3, 0, 100); send(-4, 0, 100);
    drain();
`ifdef GEMM_REQUANT_RELU_EN
    exp_w = 32'h00030001;
`else
    exp_w = 32'hFC03FE01;
`endif
    check("t1_data", got_data, exp_w);
    check("t1_mask", got_mask, 4'hF);
    check("t1_last", got_last, 0);
    check("t1_sat", perf_sat_count, 0);
    check("t1_latency", last_out_cyc - last_fire_cyc, 3);

    // T2 rounding
    set_cfg(32'd0, 16'd1, 5'd2);
    send(5, 0, 100); send(6, 0, 100); send(-6, 0, 100); send(-5, 0, 100);
    drain();
`ifdef GEMM_REQUANT_RELU_EN
    exp_w = 32'h00000201;
`else
    exp_w = 32'hFFFF0201;
`endif
    check("t2_data", got_data, exp_w);

    // T3 saturation
    clear_perf();
    set_cfg(32'd0, 16'd1000, 5'd0);
    send(1, 0, 100); send(-1, 0, 100); send(0, 0, 100); send(0, 0, 100);
    drain();
`ifdef GEMM_REQUANT_RELU_EN
    exp_w = 32'h0000007F;
`else
    exp_w = 32'h0000807F;
`endif
    check("t3_data", got_data, exp_w);
    check("t3_sat", perf_sat_count, 2);

    // Clear and clip on the same edge: clear wins
    send(5, 1, 100);
    clr_drv = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1, f);
    clr_drv = 1'b0;
    m_sat = 0;
    drain();
    check("clear_wins", perf_sat_count, 0);

    // T4 partial flush
    set_cfg(32'd0, 16'd1, 5'd0);
    send(7, 0, 100); send(8, 1, 100);
    drain();
    check("t4_data", got_data, 32'h00000807);
    check("t4_mask", got_mask, 4'h3);
    check("t4_last", got_last, 1);

    // T5 backpressure
    for (int i = 0; i < 4; i++) send(i + 10, 0, 0);
    for (int i = 0; i < 10 && !out_valid; i++) step(1'b0, '0, 1'b0, 1'b0, f);
    check("t5_out_valid", out_valid, 1);
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom_range(0, 100), 1'b0, 1'b0, f);
      check("t5_no_accept", f, 0);
      check("t5_in_ready", in_ready, 0);
      check("t5_data_stable", out_data, snap);
    end
    words0 = n_words; cyc0 = cyc;
    for (int i = 0; i < 8; i++) send(32'($urandom_range(0, 200)) - 32'd100, 0, 100);
    check("t5_back_to_back", cyc - cyc0, 8);
    drain();
    check("t5_words", n_words - words0, 3);

    // T6 reset mid-stream
    set_cfg(32'd0, 16'd1000, 5'd0);
    send(1, 0, 100); send(-1, 0, 100);
    step(1'b0, '0, 1'b0, 1'b1, f);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_sat", perf_sat_count, 0);
    check("t6_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_cfg(32'd0, 16'd1, 5'd0);
    send(1, 0, 100); send(2, 0, 100); send(3, 0, 100); send(4, 0, 100);
    drain();
    check("t6_mask", got_mask, 4'hF);
    check("t6_data", got_data, 32'h04030201);

    // Randomized groups against the reference model
    for (int g = 0; g < 60; g++) begin
      mode = $urandom_range(0, 2);
      pct  = ($urandom_range(0, 1) == 0) ? 100 : 60;
      if (mode == 0) set_cfg(32'($urandom_range(0, 200)) - 32'd100, 16'($urandom_range(0, 16)) - 16'd8, 5'($urandom_range(0, 4)));
      else if (mode == 1) set_cfg($urandom, 16'($urandom), 5'($urandom_range(0, 31)));
      else set_cfg(32'($urandom_range(0, 2000)) - 32'd1000, 16'($urandom), 5'($urandom_range(10, 24)));
      if ($urandom_range(0, 7) == 0) clear_perf();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, '0, 1'b0, $urandom_range(99) < pct, f);
        if (mode == 0) send(32'($urandom_range(0, 400)) - 32'd200, i == len - 1, pct);
        else if (mode == 1) send($urandom, i == len - 1, pct);
        else send(32'($urandom_range(0, 1 << 20)) - 32'(1 << 19), i == len - 1, pct);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
